// File: rtl/cmos_nvram_pkg.sv
// rtl/cmos_nvram_pkg.sv - shared types and defaults for the CMOS NVRAM arbiter
package cmos_nvram_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 4;
    localparam int CLEAR_VAL_DEF = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SAVE,
        ST_SAVE_WAIT,
        ST_CLEAR
    } nv_state_t;

    function automatic int nv_bytes(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int NV_BYTES = nv_bytes(ADDR_W_DEF);

endpackage

// File: rtl/cmos_nvram_arbiter_if.sv
// rtl/cmos_nvram_arbiter_if.sv - CPU, HPS ioctl and CMOS RAM signal bundle
// slave modport: arbiter view. master modport: CPU/HPS/RAM side view.
// NVRAM_DIRTY_EN adds nv_dirty.
interface cmos_nvram_arbiter_if #(
    parameter int ADDR_W = cmos_nvram_pkg::ADDR_W_DEF,
    parameter int DATA_W = cmos_nvram_pkg::DATA_W_DEF
);
    logic              cpu_cs;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_hold;
    logic              nv_sel;
    logic              ioctl_download;
    logic              ioctl_upload;
    logic              ioctl_wr;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              clear_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;
`ifdef NVRAM_DIRTY_EN
    logic              nv_dirty;
`endif

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_din, nv_sel, ioctl_download,
               ioctl_upload, ioctl_wr, ioctl_rd, ioctl_addr, ioctl_dout,
               clear_req, ram_dout,
        output cpu_dout, cpu_hold, ioctl_din, ioctl_wait, ram_addr, ram_din,
               ram_we, busy
`ifdef NVRAM_DIRTY_EN
        , output nv_dirty
`endif
    );

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_din, nv_sel, ioctl_download,
               ioctl_upload, ioctl_wr, ioctl_rd, ioctl_addr, ioctl_dout,
               clear_req, ram_dout,
        input  cpu_dout, cpu_hold, ioctl_din, ioctl_wait, ram_addr, ram_din,
               ram_we, busy
`ifdef NVRAM_DIRTY_EN
        , input nv_dirty
`endif
    );

endinterface

// File: rtl/nv_edge_detect.sv
// rtl/nv_edge_detect.sv - registered rising/falling edge detector
// Ports: clk, rst (async, active high), din level in; rise/fall one-cycle flags.
module nv_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule

// File: rtl/cmos_nvram_arbiter.sv
// rtl/cmos_nvram_arbiter.sv - CMOS NVRAM owner arbitration: CPU, HPS load/save, wipe
// Ports: clk_sys, reset (async, active high), bus (cmos_nvram_arbiter_if.slave):
//   CPU bus (cpu_*), HPS ioctl (nv_sel, ioctl_*), clear_req, RAM port (ram_*), busy.
// Optional: NVRAM_DIRTY_EN adds bus.nv_dirty (set by CPU writes/wipe, cleared by upload).
module cmos_nvram_arbiter
    import cmos_nvram_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(CLEAR_VAL_DEF)
) (
    input logic                 clk_sys,
    input logic                 reset,
    cmos_nvram_arbiter_if.slave bus
);
    localparam logic [24:0]       NV_LIMIT  = 25'(nv_bytes(ADDR_W));
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(nv_bytes(ADDR_W) - 1);

    nv_state_t         state, state_nx;
    logic              clr_pend;
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_oor;
    logic [DATA_W-1:0] cpu_dout_q;
    logic [7:0]        ioctl_din_q;

    logic clr_rise, clr_fall, dl_rise, dl_fall, ul_rise, ul_fall;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_din_c;
    logic              ram_we_c;
    logic              ioctl_wait_c;

    nv_edge_detect u_clr_edge (.clk(clk_sys), .rst(reset), .din(bus.clear_req),
                               .rise(clr_rise), .fall(clr_fall));
    nv_edge_detect u_dl_edge  (.clk(clk_sys), .rst(reset), .din(bus.ioctl_download),
                               .rise(dl_rise), .fall(dl_fall));
    nv_edge_detect u_ul_edge  (.clk(clk_sys), .rst(reset), .din(bus.ioctl_upload),
                               .rise(ul_rise), .fall(ul_fall));

    logic unused_bits;
    assign unused_bits = ^{clr_fall, dl_rise, ul_rise, bus.ioctl_dout[7:DATA_W]};

    logic addr_ok, dl_req, ul_req, clr_go, clr_last;
    assign addr_ok  = bus.ioctl_addr < NV_LIMIT;
    assign dl_req   = bus.nv_sel & bus.ioctl_download;
    assign ul_req   = bus.nv_sel & bus.ioctl_upload;
    assign clr_go   = clr_pend | clr_rise;
    assign clr_last = clr_cnt == LAST_ADDR;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (clr_go)      state_nx = ST_CLEAR;
                else if (dl_req) state_nx = ST_LOAD;
                else if (ul_req) state_nx = ST_SAVE;
            end
            ST_LOAD:      if (dl_fall) state_nx = ST_IDLE;
            ST_SAVE: begin
                if (ul_fall)           state_nx = ST_IDLE;
                else if (bus.ioctl_rd) state_nx = ST_SAVE_WAIT;
            end
            ST_SAVE_WAIT: state_nx = ul_fall ? ST_IDLE : ST_SAVE;
            ST_CLEAR:     if (clr_last) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    // RAM port mux: the CPU owns it only in IDLE; wait is held over the
    // read cycle and the data cycle so ioctl_din is valid when it drops.
    always_comb begin
        ram_addr_c   = bus.cpu_addr;
        ram_din_c    = bus.cpu_din;
        ram_we_c     = 1'b0;
        ioctl_wait_c = 1'b0;
        case (state)
            ST_IDLE:  ram_we_c = bus.cpu_cs & bus.cpu_we;
            ST_LOAD: begin
                ram_addr_c = wr_addr;
                ram_din_c  = wr_data;
                ram_we_c   = wr_pend;
            end
            ST_SAVE: begin
                ram_addr_c   = bus.ioctl_addr[ADDR_W-1:0];
                ioctl_wait_c = bus.ioctl_rd;
            end
            ST_SAVE_WAIT: begin
                ram_addr_c   = bus.ioctl_addr[ADDR_W-1:0];
                ioctl_wait_c = 1'b1;
            end
            ST_CLEAR: begin
                ram_addr_c   = clr_cnt;
                ram_din_c    = CLEAR_VAL;
                ram_we_c     = 1'b1;
                ioctl_wait_c = dl_req | ul_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            clr_pend    <= 1'b0;
            clr_cnt     <= '0;
            wr_pend     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_oor      <= 1'b0;
            cpu_dout_q  <= '0;
            ioctl_din_q <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) cpu_dout_q <= bus.ram_dout;
            if (state == ST_IDLE && clr_go)
                clr_pend <= 1'b0;
            else if (clr_rise && state inside {ST_LOAD, ST_SAVE, ST_SAVE_WAIT})
                clr_pend <= 1'b1;
            // Counter wraps back to 0 on the last wipe cycle.
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            // A strobe seen on the IDLE->LOAD cycle is kept and retired in LOAD.
            wr_pend <= bus.ioctl_wr & dl_req & addr_ok &
                       ((state == ST_LOAD) | ((state == ST_IDLE) & ~clr_go));
            if (bus.ioctl_wr) begin
                wr_addr <= bus.ioctl_addr[ADDR_W-1:0];
                wr_data <= bus.ioctl_dout[DATA_W-1:0];
            end
            if (state == ST_SAVE && bus.ioctl_rd) rd_oor <= ~addr_ok;
            if (state == ST_SAVE_WAIT) ioctl_din_q <= rd_oor ? 8'h00 : 8'(bus.ram_dout);
        end
    end

`ifdef NVRAM_DIRTY_EN
    logic dirty_q;
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            dirty_q <= 1'b0;
        else if ((state == ST_IDLE && bus.cpu_cs && bus.cpu_we) ||
                 (state == ST_CLEAR && clr_last))
            dirty_q <= 1'b1;
        else if (ul_fall && state inside {ST_SAVE, ST_SAVE_WAIT})
            dirty_q <= 1'b0;
    end
    assign bus.nv_dirty = dirty_q;
`endif

    assign bus.ram_addr   = ram_addr_c;
    assign bus.ram_din    = ram_din_c;
    assign bus.ram_we     = ram_we_c;
    assign bus.ioctl_wait = ioctl_wait_c;
    assign bus.ioctl_din  = ioctl_din_q;
    assign bus.cpu_dout   = cpu_dout_q;
    assign bus.cpu_hold   = state != ST_IDLE;
    assign bus.busy       = state != ST_IDLE;

endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
// tb/tb_cmos_nvram_arbiter.sv - directed vector bench for cmos_nvram_arbiter
module tb_cmos_nvram_arbiter;
    import cmos_nvram_pkg::*;

    logic clk_sys;
    logic reset;
    logic mem_init;
    int   n_chk;
    int   n_fail;

    cmos_nvram_arbiter_if #(.ADDR_W(10), .DATA_W(4)) bus ();

    cmos_nvram_arbiter #(.ADDR_W(10), .DATA_W(4), .CLEAR_VAL(4'h0)) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [3:0] mem [0:NV_BYTES-1];
    always @(posedge clk_sys) begin
        if (mem_init) begin
            for (int i = 0; i < NV_BYTES; i++) mem[i] <= 4'(i) ^ 4'h5;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [3:0] din;
        logic [3:0] exp_dout;
    } cpu_vec_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_we;
    } dl_vec_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  exp_din;
    } ul_vec_t;

    cpu_vec_t cv [5];
    dl_vec_t  dv [4];
    ul_vec_t  uv [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic exp_we);
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        #1;
        chk("load_we", bus.ram_we, exp_we);
        chk("load_hold", bus.cpu_hold, 1);
        tick();
    endtask

    int   cnt;
    int   nw;
    int   nonzero;
    logic found;

    initial begin
        n_chk = 0; n_fail = 0;
        cv[0] = '{1'b1, 10'h005, 4'hA, 4'h0};
        cv[1] = '{1'b0, 10'h005, 4'h0, 4'hA};
        cv[2] = '{1'b1, 10'h3FF, 4'h3, 4'h0};
        cv[3] = '{1'b0, 10'h3FF, 4'h0, 4'h3};
        cv[4] = '{1'b0, 10'h006, 4'h0, 4'h3};
        dv[0] = '{25'h000, 8'h3C, 1'b1};
        dv[1] = '{25'h001, 8'h05, 1'b1};
        dv[2] = '{25'h002, 8'hFF, 1'b1};
        dv[3] = '{25'h400, 8'h77, 1'b0};
        uv[0] = '{25'h002, 8'h0F};
        uv[1] = '{25'h000, 8'h0C};
        uv[2] = '{25'h500, 8'h00};
        uv[3] = '{25'h001, 8'h05};

        reset = 1'b1; mem_init = 1'b1;
        bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.nv_sel = 0; bus.ioctl_download = 0; bus.ioctl_upload = 0;
        bus.ioctl_wr = 0; bus.ioctl_rd = 0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
        bus.clear_req = 0;
        tick(); tick();
        mem_init = 1'b0;
        #1;
        chk("rst_cpu_dout", bus.cpu_dout, 0);
        chk("rst_cpu_hold", bus.cpu_hold, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ioctl_wait", bus.ioctl_wait, 0);
        chk("rst_ioctl_din", bus.ioctl_din, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        tick();
        reset = 1'b0;
        tick();

        // CPU access in IDLE
        for (int i = 0; i < 5; i++) begin
            bus.cpu_cs = 1'b1; bus.cpu_we = cv[i].we;
            bus.cpu_addr = cv[i].addr; bus.cpu_din = cv[i].din;
            #1;
            chk("cpu_ram_we", bus.ram_we, cv[i].we);
            chk("cpu_ram_addr", bus.ram_addr, cv[i].addr);
            chk("cpu_hold_idle", bus.cpu_hold, 0);
            tick(); tick();
            if (!cv[i].we) chk("cpu_read", bus.cpu_dout, cv[i].exp_dout);
            bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
            tick();
        end

        // Download, including one out-of-range byte
        bus.nv_sel = 1'b1; bus.ioctl_download = 1'b1;
        tick(); #1;
        chk("load_entry_hold", bus.cpu_hold, 1);
        for (int i = 0; i < 4; i++) send_byte(dv[i].addr, dv[i].data, dv[i].exp_we);
        bus.ioctl_download = 1'b0;
        tick(); #1;
        chk("load_exit_hold", bus.cpu_hold, 0);
        chk("load_mem0", mem[0], 4'hC);
        chk("load_mem1", mem[1], 4'h5);
        chk("load_mem2", mem[2], 4'hF);

        // Upload
        bus.ioctl_upload = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.ioctl_addr = uv[i].addr; bus.ioctl_rd = 1'b1; nw = 0;
            for (int k = 0; k < 4; k++) begin
                #1;
                if (bus.ioctl_wait) nw++;
                tick();
                bus.ioctl_rd = 1'b0;
            end
            chk("save_wait_cycles", nw, 2);
            chk("save_din", bus.ioctl_din, uv[i].exp_din);
        end
        bus.ioctl_upload = 1'b0;
        tick(); #1;
        chk("save_exit_busy", bus.busy, 0);
        bus.nv_sel = 1'b0;
        tick();

        // Wipe from IDLE, CPU write dropped, download queued behind it
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 1100; c++) begin
            #1;
            if (!bus.busy) break;
            cnt++;
            if (cnt == 100) begin
                bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1;
                bus.cpu_addr = 10'h010; bus.cpu_din = 4'h7;
                chk("clear_cpu_hold", bus.cpu_hold, 1);
            end
            if (cnt == 101) begin bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; end
            if (cnt == 200) begin bus.nv_sel = 1'b1; bus.ioctl_download = 1'b1; end
            if (cnt == 201) chk("clear_ioctl_wait", bus.ioctl_wait, 1);
            tick();
        end
        chk("clear_busy_cycles", cnt, 1024);
        chk("clear_end_wait", bus.ioctl_wait, 0);
        tick(); #1;
        chk("queued_load_hold", bus.cpu_hold, 1);
        send_byte(25'h020, 8'h06, 1'b1);
        bus.ioctl_download = 1'b0;
        tick();
        nonzero = 0;
        for (int i = 0; i < NV_BYTES; i++) if (i != 'h20 && mem[i] != 4'h0) nonzero++;
        chk("clear_all_zero", nonzero, 0);
        chk("clear_cpu_dropped", mem[10'h010], 4'h0);
        chk("queued_load_mem", mem[10'h020], 4'h6);

        // clear_req during download: wipe after the IDLE re-entry cycle
        bus.ioctl_download = 1'b1;
        tick();
        send_byte(25'h005, 8'h09, 1'b1);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        #1;
        chk("pend_still_load", bus.busy, 1);
        send_byte(25'h006, 8'h0E, 1'b1);
        chk("pend_loaded", mem[6], 4'hE);
        bus.ioctl_download = 1'b0;
        tick(); #1;
        chk("pend_idle_gap", bus.busy, 0);
        tick(); #1;
        chk("pend_start_busy", bus.busy, 1);
        chk("pend_start_addr", bus.ram_addr, 0);
        chk("pend_start_we", bus.ram_we, 1);
        cnt = 0;
        for (int c = 0; c < 1100; c++) begin
            if (!bus.busy) break;
            cnt++;
            tick(); #1;
        end
        chk("pend_busy_cycles", cnt, 1024);
        chk("pend_wiped5", mem[5], 4'h0);
        chk("pend_wiped6", mem[6], 4'h0);

        // Async reset in the middle of a wipe
        bus.cpu_addr = '0; bus.cpu_din = '0;
        tick();
        bus.ioctl_download = 1'b1;
        tick();
        send_byte(25'h1FF, 8'h01, 1'b1);
        send_byte(25'h200, 8'h2A, 1'b1);
        send_byte(25'h2AB, 8'h3B, 1'b1);
        send_byte(25'h3FF, 8'h4D, 1'b1);
        bus.ioctl_download = 1'b0;
        tick();
        bus.nv_sel = 1'b0;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_addr = 25'h001;
        bus.nv_sel = 1'b1;
        tick();
        bus.ioctl_rd = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        tick();
        bus.ioctl_upload = 1'b0;
        tick();
        bus.nv_sel = 1'b0;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            #1;
            if (bus.busy && bus.ram_we && bus.ram_addr == 10'h200) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wipe_reached_200", found, 1);
        reset = 1'b1;
        #1;
        chk("async_busy", bus.busy, 0);
        chk("async_hold", bus.cpu_hold, 0);
        chk("async_ram_we", bus.ram_we, 0);
        chk("async_ram_addr", bus.ram_addr, 0);
        chk("async_ioctl_din", bus.ioctl_din, 0);
        chk("async_ioctl_wait", bus.ioctl_wait, 0);
        chk("async_cpu_dout", bus.cpu_dout, 0);
        tick();
        reset = 1'b0;
        tick(); tick(); #1;
        chk("reset_idle", bus.busy, 0);
        chk("partial_1ff", mem[10'h1FF], 4'h0);
        chk("kept_200", mem[10'h200], 4'hA);
        chk("kept_2ab", mem[10'h2AB], 4'hB);
        chk("kept_3ff", mem[10'h3FF], 4'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
